// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory word address,
// and registers fetched words into an IF/ID slot with a valid/ready handshake toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // state | meaning
  // BOOT  | single idle cycle after reset release, no fetch
  // RUN   | normal fetch, redirect and back-pressure handling
  // HALT  | halt word captured; drain it to decode, then idle until reset
  // ERR   | misaligned redirect or out-of-range fetch; idle until reset
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT, ST_ERR} state_t;

  localparam logic [31:0] LP_IMEM_WORDS = 32'(IMEM_WORDS);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_out_valid, w_valid_nxt;
  logic [31:0] r_out_instr, w_instr_nxt;
  logic [31:0] r_out_pc, w_opc_nxt;
  logic        r_halted, w_halted_nxt;
  logic        r_fault, w_fault_nxt;
  logic [31:0] r_fetch_count;

  logic        w_accept;
  logic        w_advance;
  logic        w_out_of_range;

  assign iaddr          = {2'b00, r_pc[31:2]};
  assign w_accept       = r_out_valid & out_ready;
  assign w_advance      = ~r_out_valid | out_ready;
  assign w_out_of_range = (iaddr >= LP_IMEM_WORDS);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_valid_nxt  = r_out_valid;
    w_instr_nxt  = r_out_instr;
    w_opc_nxt    = r_out_pc;
    w_halted_nxt = r_halted;
    w_fault_nxt  = r_fault;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          w_fault_nxt = 1'b1;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_ERR;
        end else if (redirect_valid) begin
          // Flush the slot; the target is fetched on the following edge.
          w_pc_nxt    = redirect_target;
          w_valid_nxt = 1'b0;
        end else if (w_advance && w_out_of_range) begin
          w_fault_nxt = 1'b1;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_ERR;
        end else if (w_advance) begin
          w_instr_nxt = idata;
          w_opc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          if (idata == HALT_WORD) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = ST_HALT;
          end else begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
      end
      ST_HALT: begin
        if (w_accept) w_valid_nxt = 1'b0;
      end
      ST_ERR:  w_valid_nxt = 1'b0;
      default: w_state_nxt = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'h0;
      r_out_pc      <= 32'h0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_instr <= w_instr_nxt;
      r_out_pc    <= w_opc_nxt;
      r_halted    <= w_halted_nxt;
      r_fault     <= w_fault_nxt;
      if (w_accept) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. It holds the program counter (PC) and drives the memory's word address. It captures the returned instruction into a registered IF/ID output with a valid/ready handshake toward decode. It also handles branch/jump redirects, back-pressure, a halt instruction, and fault detection for misaligned or out-of-range PCs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_WORDS, 32, number of words in instruction memory. Word indices ≥ IMEM_WORDS are out of range.
- HALT_WORD, 32'hFFFF_FFFF, encoding that halts fetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iaddr  out  32  word index to instruction memory, equal to {2'b00, pc[31:2]}.
- idata  in  32  instruction word from memory, combinational in iaddr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  byte address of the new PC.
- out_ready  in  1  decode accepts out_instr this cycle.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  byte PC of out_instr.
- halted  out  1  sticky; set when HALT_WORD has been captured.
- fault  out  1  sticky; misaligned redirect or out-of-range fetch.
- fetch_count  out  32  number of accepted handshakes (out_valid && out_ready); wraps modulo 2^32.

## Operation
States:
- BOOT: one cycle after reset release. No fetch; goes to RUN unconditionally.
- RUN: normal fetch.
- HALT: terminal until reset.
- ERR: terminal until reset.

Reset (asynchronous):
- pc=RESET_PC, state=BOOT.
- out_valid=0, out_instr=0, out_pc=0.
- halted=0, fault=0, fetch_count=0.

In RUN, evaluated at each edge with priority top-down:
1. redirect_valid=1 and redirect_target[1:0]≠0: fault←1, out_valid←0, state←ERR.
2. redirect_valid=1 and target aligned: pc←redirect_target, out_valid←0 (flush). No capture this cycle.
3. pc word index ≥ IMEM_WORDS and (out_valid=0 or out_ready=1): fault←1, out_valid←0, state←ERR.
4. out_valid=0 or out_ready=1 (advance): out_instr←idata, out_pc←pc, out_valid←1, pc←pc+4 (wraps modulo 2^32). If idata==HALT_WORD: halted←1, state←HALT, pc unchanged.
5. Otherwise (out_valid=1, out_ready=0): hold pc and all outputs.

Behaviour in HALT:
- The halt word stays presented until accepted, then out_valid←0.
- No further fetches. redirect_valid is ignored.

Behaviour in ERR:
- out_valid=0. Redirects and fetches are ignored.

fetch_count:
- Increments on every edge where out_valid && out_ready, in any state, including the cycle a redirect flushes.
- A redirect arriving in the same cycle as an accept still counts the accept.

## Timing
- iaddr is combinational from the pc register; idata is sampled at the same edge that advances pc.
- Reset release to first out_valid=1: 2 edges (BOOT edge, then capture edge).
- Throughput: one instruction per cycle while out_ready=1.
- Redirect sampled at edge N: out_valid=0 after N. The target instruction is valid after edge N+1 and carries out_pc=redirect_target.
- Back-pressure: out_instr/out_pc stay stable while out_valid=1 and out_ready=0; no instruction is dropped or duplicated.
- fault and halted assert at the edge of detection and never deassert without rst_n.
- rst_n asserted mid-operation: all outputs return to their reset values immediately, without waiting for clk.

## Test plan
- Reset and sequential fetch: memory words 0..3 = 11,22,33,44; out_ready=1 → after edge 2, out_instr=11, out_pc=0. Next three cycles give 22/4, 33/8, 44/12; fetch_count=4 after the fourth accept.
- Stall: out_ready=0 for 3 cycles while out_instr=22 → out_instr=22, out_pc=4 held. Releasing gives 33/8 next, with no skip or repeat.
- Redirect: redirect_target=0x20 while word 8=0xAA → one bubble (out_valid=0), then out_instr=0xAA, out_pc=0x20.
- Misaligned redirect: redirect_target=0x22 → fault=1, out_valid=0 from the next cycle. Later redirects are ignored.
- Halt: word 2=HALT_WORD, out_ready=1 → HALT_WORD delivered with out_pc=8 and halted=1. out_valid=0 afterwards; a later redirect has no effect.
- Out of range: sequential fetch reaches pc=0x80 (index 32) → fault=1, out_valid=0, and the last valid out_pc is 0x7C.
